// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: upstream slot, stage control and register-file write port.
// The memory stage drives the master side; mem_wb_stage uses the slave side.
interface mem_wb_stage_if;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic [3:0]  in_dst_reg;
    logic [1:0]  in_wb_sel;
    logic [15:0] in_alu_result;
    logic [15:0] in_mem_data;
    logic [15:0] in_pc_next;
    logic        in_halt;
    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic        wb_valid;
    logic        halted;
    logic [15:0] retire_count;

    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_dst_reg, in_wb_sel,
               in_alu_result, in_mem_data, in_pc_next, in_halt,
        output WriteReg, DstReg, DstData, wb_valid, halted, retire_count
    );

    modport master (
        output stall, flush, in_valid, in_reg_write, in_dst_reg, in_wb_sel,
               in_alu_result, in_mem_data, in_pc_next, in_halt,
        input  WriteReg, DstReg, DstData, wb_valid, halted, retire_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback selector for the 16-bit CPU.
// Captures memory-stage results, drives the register-file write port,
// freezes retirement once HLT reaches writeback (sticky until reset).
// Optional feature macro: MEMWB_RETIRE_CNT_EN enables a saturating
// retired-instruction counter; when undefined retire_count is tied to zero.
module mem_wb_stage (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);

    logic        r_valid;
    logic        r_reg_write;
    logic        r_halt;
    logic        r_halted;
    logic [3:0]  r_dst;
    logic [1:0]  r_sel;
    logic [15:0] r_alu;
    logic [15:0] r_mem;
    logic [15:0] r_pc;

    logic        w_ld;
    logic        w_retire;
    logic        w_halt_load;

    // Writeback source select; code 11 deliberately yields zero.
    function automatic logic [15:0] wb_mux(
        input logic [1:0]  sel,
        input logic [15:0] alu,
        input logic [15:0] mem,
        input logic [15:0] pc
    );
        logic [15:0] res;
        case (sel)
            2'b00:   res = alu;
            2'b01:   res = mem;
            2'b10:   res = pc;
            default: res = 16'h0000;
        endcase
        return res;
    endfunction

    // A frozen (halted) stage never loads again, so halted gates the load.
    assign w_ld        = ~bus.stall & ~r_halted;
    assign w_retire    = w_ld & ~bus.flush & bus.in_valid;
    assign w_halt_load = w_retire & bus.in_halt;

    // Stage register: halted hold > flush bubble > load > stall hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_halt      <= 1'b0;
            r_dst       <= 4'h0;
            r_sel       <= 2'b00;
            r_alu       <= 16'h0000;
            r_mem       <= 16'h0000;
            r_pc        <= 16'h0000;
        end else if (r_halted) begin
            r_valid     <= r_valid;
            r_reg_write <= r_reg_write;
            r_halt      <= r_halt;
        end else if (bus.flush) begin
            // Data fields are don't-care in a bubble; keep them to save toggles.
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_halt      <= 1'b0;
        end else if (w_ld) begin
            r_valid     <= bus.in_valid;
            r_reg_write <= bus.in_reg_write;
            r_halt      <= bus.in_halt;
            r_dst       <= bus.in_dst_reg;
            r_sel       <= bus.in_wb_sel;
            r_alu       <= bus.in_alu_result;
            r_mem       <= bus.in_mem_data;
            r_pc        <= bus.in_pc_next;
        end else begin
            r_valid     <= r_valid;
            r_reg_write <= r_reg_write;
            r_halt      <= r_halt;
        end
    end

    // Sticky halt flag: set when a valid HLT is captured, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted <= 1'b0;
        end else if (w_halt_load) begin
            r_halted <= 1'b1;
        end else begin
            r_halted <= r_halted;
        end
    end

`ifdef MEMWB_RETIRE_CNT_EN
    logic [15:0] r_retire_cnt;

    // Saturating count of valid instructions captured (HLT included).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_cnt <= 16'h0000;
        end else if (w_retire && (r_retire_cnt != 16'hFFFF)) begin
            r_retire_cnt <= r_retire_cnt + 16'h0001;
        end else begin
            r_retire_cnt <= r_retire_cnt;
        end
    end

    assign bus.retire_count = r_retire_cnt;
`else
    assign bus.retire_count = 16'h0000;
`endif

    // HLT never writes; a held (stalled) instruction keeps rewriting its value.
    assign bus.WriteReg = r_valid & r_reg_write & ~r_halt;
    assign bus.DstReg   = r_dst;
    assign bus.DstData  = wb_mux(r_sel, r_alu, r_mem, r_pc);
    assign bus.wb_valid = r_valid;
    assign bus.halted   = r_halted;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_mem_wb_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the register-file port should show right now.
    logic        m_valid;
    logic        m_we;
    logic [3:0]  m_dst;
    logic [15:0] m_data;
    logic        m_halted;
    int          m_count;

    task automatic model_reset();
        m_valid  = 1'b0;
        m_we     = 1'b0;
        m_dst    = 4'h0;
        m_data   = 16'h0000;
        m_halted = 1'b0;
        m_count  = 0;
    endtask

    // Apply one clock edge worth of the stage's rules to the model.
    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (bus.flush) begin
            m_valid = 1'b0;
            m_we    = 1'b0;
        end else if (!bus.stall) begin
            m_valid = bus.in_valid;
            m_we    = bus.in_valid && bus.in_reg_write && !bus.in_halt;
            m_dst   = bus.in_dst_reg;
            if (bus.in_wb_sel == 2'd0)      m_data = bus.in_alu_result;
            else if (bus.in_wb_sel == 2'd1) m_data = bus.in_mem_data;
            else if (bus.in_wb_sel == 2'd2) m_data = bus.in_pc_next;
            else                            m_data = 16'h0000;
            if (bus.in_valid && bus.in_halt) m_halted = 1'b1;
            if (bus.in_valid && m_count < 65535) m_count = m_count + 1;
        end
    endtask

    function automatic int exp_count();
`ifdef MEMWB_RETIRE_CNT_EN
        return m_count;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_reg_write  = 1'b0;
        bus.in_dst_reg    = 4'h0;
        bus.in_wb_sel     = 2'b00;
        bus.in_alu_result = 16'h0000;
        bus.in_mem_data   = 16'h0000;
        bus.in_pc_next    = 16'h0000;
        bus.in_halt       = 1'b0;
    endtask

    task automatic drive(input logic [3:0] dst, input logic [1:0] sel,
                         input logic [15:0] alu, input logic [15:0] mem,
                         input logic [15:0] pc);
        bus.in_valid      = 1'b1;
        bus.in_reg_write  = 1'b1;
        bus.in_halt       = 1'b0;
        bus.in_dst_reg    = dst;
        bus.in_wb_sel     = sel;
        bus.in_alu_result = alu;
        bus.in_mem_data   = mem;
        bus.in_pc_next    = pc;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.WriteReg !== 1'b0 || bus.DstReg !== 4'h0 || bus.DstData !== 16'h0000 ||
                bus.wb_valid !== 1'b0 || bus.halted !== 1'b0 || bus.retire_count !== 16'h0000) begin
                errors++;
                $display("FAIL reset_outputs: got we=%b dst=%h data=%h v=%b h=%b cnt=%h, want all zero",
                         bus.WriteReg, bus.DstReg, bus.DstData, bus.wb_valid, bus.halted, bus.retire_count);
            end
        end
        rst = 1'b1;
        drive(4'h3, 2'b00, 16'h1111, 16'h2222, 16'h3333);
        tick();
        checks++;
        if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'h3 || bus.DstData !== 16'h1111) begin
            errors++;
            $display("FAIL first_alu_write: got we=%b dst=%h data=%h, want 1 3 1111",
                     bus.WriteReg, bus.DstReg, bus.DstData);
        end
    endtask

    task automatic test_wb_select();
        logic [15:0] want [4];
        want[0] = 16'h5A5A; want[1] = 16'hFFFF; want[2] = 16'h0042; want[3] = 16'h0000;
        for (int s = 0; s < 4; s++) begin
            drive(4'(s + 8), 2'(s), 16'h5A5A, 16'hFFFF, 16'h0042);
            tick();
            checks++;
            if (bus.DstData !== want[s] || bus.DstReg !== 4'(s + 8) || bus.WriteReg !== 1'b1) begin
                errors++;
                $display("FAIL wb_select sel=%0d: got data=%h dst=%h we=%b, want data=%h dst=%h we=1",
                         s, bus.DstData, bus.DstReg, bus.WriteReg, want[s], 4'(s + 8));
            end
        end
    endtask

    task automatic test_stall_flush();
        drive(4'h5, 2'b00, 16'hABCD, 16'h0000, 16'h0000);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(4'(i), 2'b01, 16'(i * 7), 16'h9999, 16'h1234);
            tick();
            checks++;
            if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'h5 || bus.DstData !== 16'hABCD) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got we=%b dst=%h data=%h, want 1 5 abcd",
                         i, bus.WriteReg, bus.DstReg, bus.DstData);
            end
        end
        bus.flush = 1'b1;
        tick();
        checks++;
        if (bus.WriteReg !== 1'b0 || bus.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_over_stall: got we=%b valid=%b, want 0 0", bus.WriteReg, bus.wb_valid);
        end
        idle_inputs();
        drive(4'h6, 2'b00, 16'h0F0F, 16'h0000, 16'h0000);
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.WriteReg !== 1'b0 || bus.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL invalid_bubble: got we=%b valid=%b, want 0 0", bus.WriteReg, bus.wb_valid);
        end
    endtask

    task automatic test_halt();
        drive(4'h2, 2'b00, 16'h7777, 16'h0000, 16'h0000);
        bus.in_halt = 1'b1;
        tick();
        checks++;
        if (bus.halted !== 1'b1 || bus.WriteReg !== 1'b0 || bus.wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL halt_capture: got halted=%b we=%b valid=%b, want 1 0 1",
                     bus.halted, bus.WriteReg, bus.wb_valid);
        end
        drive(4'h7, 2'b00, 16'hBEEF, 16'h0000, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            bus.flush = (i >= 2) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if (bus.halted !== 1'b1 || bus.WriteReg !== 1'b0 || bus.wb_valid !== 1'b1 ||
                bus.DstReg !== 4'h2) begin
                errors++;
                $display("FAIL halt_frozen cycle %0d: got halted=%b we=%b valid=%b dst=%h, want 1 0 1 2",
                         i, bus.halted, bus.WriteReg, bus.wb_valid, bus.DstReg);
            end
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.halted !== 1'b0 || bus.retire_count !== 16'h0000 || bus.wb_valid !== 1'b0 ||
            bus.WriteReg !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got halted=%b cnt=%h valid=%b we=%b, want all zero",
                     bus.halted, bus.retire_count, bus.wb_valid, bus.WriteReg);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
    endtask

    task automatic test_counter();
        int want;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'(i), 2'b00, 16'(i), 16'h0000, 16'h0000);
            tick();
        end
        idle_inputs();
        tick();
        tick();
        drive(4'hC, 2'b00, 16'h4444, 16'h0000, 16'h0000);
        bus.flush = 1'b1;
        tick();
        idle_inputs();
`ifdef MEMWB_RETIRE_CNT_EN
        want = 5;
`else
        want = 0;
`endif
        checks++;
        if (bus.retire_count !== 16'(want)) begin
            errors++;
            $display("FAIL retire_count: got %0d, want %0d", bus.retire_count, want);
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int i = 0; i < 120; i++) begin
                bus.stall         = ($urandom_range(3) == 0);
                bus.flush         = ($urandom_range(9) == 0);
                bus.in_valid      = ($urandom_range(4) != 0);
                bus.in_reg_write  = ($urandom_range(3) != 0);
                bus.in_dst_reg    = 4'($urandom);
                bus.in_wb_sel     = 2'($urandom);
                bus.in_alu_result = 16'($urandom);
                bus.in_mem_data   = 16'($urandom);
                bus.in_pc_next    = 16'($urandom);
                bus.in_halt       = ($urandom_range(59) == 0);
                tick();
                checks++;
                if (bus.WriteReg !== m_we || bus.wb_valid !== m_valid || bus.halted !== m_halted ||
                    bus.retire_count !== 16'(exp_count())) begin
                    errors++;
                    $display("FAIL random_ctrl seg%0d cyc%0d: got we=%b v=%b h=%b cnt=%0d, want we=%b v=%b h=%b cnt=%0d",
                             seg, i, bus.WriteReg, bus.wb_valid, bus.halted, bus.retire_count,
                             m_we, m_valid, m_halted, exp_count());
                end
                if (m_valid) begin
                    checks++;
                    if (bus.DstReg !== m_dst || bus.DstData !== m_data) begin
                        errors++;
                        $display("FAIL random_data seg%0d cyc%0d: got dst=%h data=%h, want dst=%h data=%h",
                                 seg, i, bus.DstReg, bus.DstData, m_dst, m_data);
                    end
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_wb_select();
        test_stall_flush();
        test_halt();
        test_async_reset();
        test_counter();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
